// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the device receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    STOP,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;

  // Enough to count the 9 data+parity bits of a frame.
  localparam int BIT_CNT_W = 4;

  function automatic int inhibit_cyc(input int clk_hz, input int inhibit_us);
    return (clk_hz / 1_000_000) * inhibit_us;
  endfunction

  function automatic int timeout_cyc(input int clk_hz, input int timeout_us);
    return (clk_hz / 1_000_000) * timeout_us;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// One PS/2 line: 2-FF synchronizer, falling-edge detector and, when
// PS2_TX_GLITCH_FILTER_EN is defined, a 4-sample stability filter in between.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic [1:0] sync_q;
  logic       level_q;
  logic       prev_q;

  // Idle PS/2 lines are high, so reset to 1 to avoid a false fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], pin};
    end
  end

`ifdef PS2_TX_GLITCH_FILTER_EN
  logic [2:0] hist_q;
  logic [3:0] window;

  assign window = {hist_q, sync_q[1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q  <= 3'b111;
      level_q <= 1'b1;
    end else begin
      hist_q <= window[2:0];
      if (&window) begin
        level_q <= 1'b1;
      end else if (~|window) begin
        level_q <= 1'b0;
      end
    end
  end
`else
  assign level_q = sync_q[1];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= level_q;
    end
  end

  assign level = level_q;
  assign fall  = prev_q & ~level_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter (open-drain enables only).
// Build option: PS2_TX_GLITCH_FILTER_EN adds a 4-sample input filter.
//
// state     | meaning
// IDLE      | ready for a byte, both lines released
// INHIBIT   | clock pulled low (request-to-send)
// REQ       | start bit driven, clock still held: last inhibit cycle
// SHIFT     | place D0..D7 and parity on device clock falls
// STOP      | release data for the stop bit
// ACK       | sample device ack on the next fall
// WAIT_IDLE | wait for both lines high, then report done
module ps2_host_tx #(
  parameter int CLK_HZ     = 25_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);
  import ps2_pkg::*;

  localparam int INH_CYC = inhibit_cyc(CLK_HZ, INHIBIT_US);
  localparam int TO_CYC  = timeout_cyc(CLK_HZ, TIMEOUT_US);
  localparam int TMR_W   = $clog2(((INH_CYC > TO_CYC) ? INH_CYC : TO_CYC) + 1);
  // INHIBIT lasts INH_CYC-1 cycles and REQ one more, so clk_oe is high INH_CYC cycles.
  localparam logic [TMR_W-1:0] INH_LOAD = TMR_W'(INH_CYC - 2);
  localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'(TO_CYC - 1);

  ps2_tx_state_t        state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [8:0]           shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 data_oe_q, data_oe_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic clk_lvl, clk_fall, data_lvl, data_fall_unused;
  logic tmr_zero;

  ps2_line_sync u_clk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (ps2_clk_i),
    .level (clk_lvl),
    .fall  (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (ps2_data_i),
    .level (data_lvl),
    .fall  (data_fall_unused)
  );

  assign tmr_zero = (tmr_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          shreg_d   = {~^tx_data, tx_data};
          bit_cnt_d = '0;
          tmr_d     = INH_LOAD;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (tmr_zero) begin
          data_oe_d = 1'b1;
          state_d   = REQ;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      REQ: begin
        tmr_d   = TO_LOAD;
        state_d = SHIFT;
      end
      SHIFT, STOP, ACK, WAIT_IDLE: begin
        // Timeout wins over any fall seen in the same cycle.
        if (tmr_zero) begin
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
          case (state_q)
            SHIFT: begin
              if (clk_fall) begin
                data_oe_d = ~shreg_q[0];
                shreg_d   = shreg_q >> 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BIT_CNT_W'(8)) begin
                  state_d = STOP;
                end
              end
            end
            STOP: begin
              if (clk_fall) begin
                data_oe_d = 1'b0;
                state_d   = ACK;
              end
            end
            ACK: begin
              if (clk_fall) begin
                if (data_lvl) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
                end else begin
                  state_d = WAIT_IDLE;
                end
              end
            end
            WAIT_IDLE: begin
              if (clk_lvl && data_lvl) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end
            end
            default: state_d = IDLE;
          endcase
        end
      end
      default: begin
        data_oe_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // The pulse cycle already sits in IDLE; readiness returns one cycle later.
  assign tx_ready    = (state_q == IDLE) && !(done_q || err_q);
  assign busy        = (state_q != IDLE);
  assign ps2_clk_oe  = (state_q == INHIBIT) || (state_q == REQ);
  assign ps2_data_oe = data_oe_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;

endmodule
